// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Datapath.
// It fetches at T0-T2, decodes IR, executes ALU register ops and stops on halt.
module control_sequencer #(
    parameter int ALU_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Mem_Ready,
    input  logic [31:0]      IR,
    output logic             PC_Out,
    output logic             ZLO_Out,
    output logic             MDR_Out,
    output logic             MAR_In,
    output logic             PC_In,
    output logic             MDR_In,
    output logic             IR_In,
    output logic             Y_In,
    output logic             Z_In,
    output logic             IncPC,
    output logic             Read,
    output logic [15:0]      R_In,
    output logic [15:0]      R_Out,
    output logic [ALU_W-1:0] CONTROL,
    output logic             Run,
    output logic             Illegal,
    output logic [CNT_W-1:0] Instr_Count
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;

    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_bin;
    logic        w_un;
    logic        w_halt;
    logic        w_ill;
    logic [4:0]  w_ctl;
    logic        w_retire;
    logic        w_unused;

    assign w_op     = IR[31:27];
    assign w_ra     = IR[26:23];
    assign w_rb     = IR[22:19];
    assign w_rc     = IR[18:15];
    assign w_unused = ^IR[14:0];

    assign w_bin  = (w_op <= 5'b01000);
    assign w_un   = (w_op == 5'b01001) || (w_op == 5'b01010);
    assign w_halt = (w_op == 5'b11011);
    assign w_ill  = !(w_bin || w_un || w_halt);

    // Unary ops map onto ALU codes one above their opcode
    assign w_ctl = w_bin ? w_op :
                   (w_op == 5'b01001) ? 5'b01010 : 5'b01011;

    assign w_retire = ((r_state == S_T4) && w_un) || (r_state == S_T5);

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign Instr_Count = r_count;

    always_comb begin
        w_next  = r_state;
        PC_Out  = 1'b0;
        ZLO_Out = 1'b0;
        MDR_Out = 1'b0;
        MAR_In  = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        Z_In    = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        R_In    = '0;
        R_Out   = '0;
        CONTROL = '0;
        Illegal = 1'b0;
        Run     = (r_state != S_IDLE) && (r_state != S_HALT);
        unique case (r_state)
            S_IDLE: begin
                if (Start) w_next = S_T0;
            end
            S_T0: begin
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
                Z_In   = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                ZLO_Out = 1'b1;
                PC_In   = 1'b1;
                Read    = 1'b1;
                MDR_In  = 1'b1;
                if (Mem_Ready) w_next = S_T2;
            end
            S_T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
                w_next  = S_T3;
            end
            S_T3: begin
                if (w_halt) begin
                    w_next = S_HALT;
                end else if (w_ill) begin
                    Illegal = 1'b1;
                    w_next  = S_T0;
                end else begin
                    R_Out = 16'(1) << w_rb;
                    if (w_bin) begin
                        Y_In = 1'b1;
                    end else begin
                        CONTROL = ALU_W'(w_ctl);
                        Z_In    = 1'b1;
                    end
                    w_next = S_T4;
                end
            end
            S_T4: begin
                if (w_un) begin
                    ZLO_Out = 1'b1;
                    R_In    = 16'(1) << w_ra;
                    w_next  = S_T0;
                end else begin
                    R_Out   = 16'(1) << w_rc;
                    CONTROL = ALU_W'(w_ctl);
                    Z_In    = 1'b1;
                    w_next  = S_T5;
                end
            end
            S_T5: begin
                ZLO_Out = 1'b1;
                R_In    = 16'(1) << w_ra;
                w_next  = S_T0;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed table, random instruction stream
// against a per-instruction cycle-sequence model, plus halt and abort cases.
module tb_control_sequencer;

    typedef struct packed {
        logic        pc_out, zlo_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
        logic        y_in, z_in, incpc, read, run, illegal;
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic [4:0]  ctl;
    } outs_t;

    typedef struct {
        logic [31:0] ir;
        int          stalls;
        int          len;
        logic [15:0] t3_rout;
        logic [4:0]  t3_ctl;
        int          ill;
        int          dcnt;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Clear, Start, Mem_Ready;
    logic [31:0] IR;
    logic        PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In;
    logic        Y_In, Z_In, IncPC, Read, Run, Illegal;
    logic [15:0] R_In, R_Out, Instr_Count;
    logic [4:0]  CONTROL;

    int    checks = 0;
    int    errors = 0;
    int    model_count = 0;
    outs_t dut_o;
    outs_t exp_q[$];
    vec_t  vecs[5];

    control_sequencer #(.ALU_W(5), .CNT_W(16)) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Mem_Ready(Mem_Ready),
        .IR(IR), .PC_Out(PC_Out), .ZLO_Out(ZLO_Out), .MDR_Out(MDR_Out),
        .MAR_In(MAR_In), .PC_In(PC_In), .MDR_In(MDR_In), .IR_In(IR_In),
        .Y_In(Y_In), .Z_In(Z_In), .IncPC(IncPC), .Read(Read), .R_In(R_In),
        .R_Out(R_Out), .CONTROL(CONTROL), .Run(Run), .Illegal(Illegal),
        .Instr_Count(Instr_Count)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        dut_o = '0;
        dut_o.pc_out = PC_Out;   dut_o.zlo_out = ZLO_Out;
        dut_o.mdr_out = MDR_Out; dut_o.mar_in = MAR_In;
        dut_o.pc_in = PC_In;     dut_o.mdr_in = MDR_In;
        dut_o.ir_in = IR_In;     dut_o.y_in = Y_In;
        dut_o.z_in = Z_In;       dut_o.incpc = IncPC;
        dut_o.read = Read;       dut_o.run = Run;
        dut_o.illegal = Illegal; dut_o.r_in = R_In;
        dut_o.r_out = R_Out;     dut_o.ctl = CONTROL;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expand one instruction into the list of per-cycle output sets
    task automatic plan(input logic [31:0] ir, input int stalls,
                        output int retire);
        outs_t o;
        int op;
        op = int'(ir[31:27]);
        exp_q.delete();
        o = '0; o.run = 1; o.pc_out = 1; o.mar_in = 1; o.incpc = 1; o.z_in = 1;
        exp_q.push_back(o);
        for (int s = 0; s <= stalls; s++) begin
            o = '0; o.run = 1; o.zlo_out = 1; o.pc_in = 1; o.read = 1;
            o.mdr_in = 1;
            exp_q.push_back(o);
        end
        o = '0; o.run = 1; o.mdr_out = 1; o.ir_in = 1;
        exp_q.push_back(o);
        retire = 0;
        if (op <= 8) begin
            o = '0; o.run = 1; o.r_out = 16'(1) << ir[22:19]; o.y_in = 1;
            exp_q.push_back(o);
            o = '0; o.run = 1; o.r_out = 16'(1) << ir[18:15];
            o.ctl = 5'(op); o.z_in = 1;
            exp_q.push_back(o);
            o = '0; o.run = 1; o.zlo_out = 1; o.r_in = 16'(1) << ir[26:23];
            exp_q.push_back(o);
            retire = 1;
        end else if (op == 9 || op == 10) begin
            o = '0; o.run = 1; o.r_out = 16'(1) << ir[22:19];
            o.ctl = 5'(op + 1); o.z_in = 1;
            exp_q.push_back(o);
            o = '0; o.run = 1; o.zlo_out = 1; o.r_in = 16'(1) << ir[26:23];
            exp_q.push_back(o);
            retire = 1;
        end else if (op == 27) begin
            o = '0; o.run = 1;
            exp_q.push_back(o);
        end else begin
            o = '0; o.run = 1; o.illegal = 1;
            exp_q.push_back(o);
        end
    endtask

    // Entered and left #1 after a rising edge, with the DUT in T0
    task automatic exec(input logic [31:0] ir, input int stalls,
                        input int abort_at, output int len,
                        output logic [15:0] t3_rout, output logic [4:0] t3_ctl,
                        output int ill, output int dcnt);
        int retire;
        int cnt0;
        plan(ir, stalls, retire);
        cnt0 = int'(Instr_Count);
        ill = 0;
        t3_rout = '0;
        t3_ctl = '0;
        len = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("outs_c%0d", i), 64'(dut_o), 64'(exp_q[i]));
            chk("count", 64'(Instr_Count), 64'(model_count[15:0]));
            if (i == 3 + stalls) begin
                t3_rout = R_Out;
                t3_ctl = CONTROL;
            end
            ill += int'(Illegal);
            if (i == 0) IR = ir;
            Start = 1'($urandom);
            if (i >= 1 && i <= 1 + stalls) Mem_Ready = (i == 1 + stalls);
            else Mem_Ready = 1'($urandom);
            if (i == abort_at) begin
                Clear = 1'b1;
                Start = 1'b1;
                @(posedge Clock);
                #1;
                Clear = 1'b0;
                Start = 1'b0;
                model_count = 0;
                dcnt = 0;
                return;
            end
            @(posedge Clock);
            #1;
        end
        model_count += retire;
        dcnt = int'(Instr_Count) - cnt0;
        if (ir[31:27] != 5'd27) begin
            chk("next_T0", 64'(PC_Out && MAR_In), 64'd1);
            if (PC_Out && MAR_In) len = exp_q.size();
        end
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
    endtask

    initial begin
        int len, ill, dcnt;
        logic [15:0] rout;
        logic [4:0] ctl;
        logic [4:0] op;

        vecs[0] = '{32'h4A920000, 0, 5, 16'h0004, 5'b01010, 0, 1};
        vecs[1] = '{32'h01A20000, 0, 6, 16'h0010, 5'b00000, 0, 1};
        vecs[2] = '{32'h01A20000, 3, 9, 16'h0010, 5'b00000, 0, 1};
        vecs[3] = '{32'h50F80000, 1, 6, 16'h8000, 5'b01011, 0, 1};
        vecs[4] = '{32'hE0000000, 0, 4, 16'h0000, 5'b00000, 1, 0};

        Clear = 1'b1; Start = 1'b1; Mem_Ready = 1'b1; IR = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_outs", 64'(dut_o), 64'd0);
        chk("reset_count", 64'(Instr_Count), 64'd0);
        Clear = 1'b0; Start = 1'b0;
        @(posedge Clock);
        #1;
        chk("idle_hold", 64'(dut_o), 64'd0);
        start_pulse();

        foreach (vecs[k]) begin
            exec(vecs[k].ir, vecs[k].stalls, -1, len, rout, ctl, ill, dcnt);
            chk($sformatf("v%0d_len", k), 64'(len), 64'(vecs[k].len));
            chk($sformatf("v%0d_t3_rout", k), 64'(rout), 64'(vecs[k].t3_rout));
            chk($sformatf("v%0d_t3_ctl", k), 64'(ctl), 64'(vecs[k].t3_ctl));
            chk($sformatf("v%0d_ill", k), 64'(ill), 64'(vecs[k].ill));
            chk($sformatf("v%0d_dcnt", k), 64'(dcnt), 64'(vecs[k].dcnt));
        end

        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) op = 5'($urandom_range(0, 8));
            else if (r < 8) op = 5'($urandom_range(9, 10));
            else begin
                op = 5'd27;
                while (op == 5'd27) op = 5'($urandom_range(11, 31));
            end
            exec({op, 27'($urandom)}, int'($urandom_range(0, 3)), -1,
                 len, rout, ctl, ill, dcnt);
        end

        exec({5'd27, 27'h2A5A5A5}, 0, -1, len, rout, ctl, ill, dcnt);
        for (int i = 0; i < 4; i++) begin
            chk("halt_outs", 64'(dut_o), 64'd0);
            chk("halt_count", 64'(Instr_Count), 64'(model_count[15:0]));
            Start = 1'($urandom);
            Mem_Ready = 1'($urandom);
            @(posedge Clock);
            #1;
        end
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0; Start = 1'b0;
        model_count = 0;
        chk("post_halt_outs", 64'(dut_o), 64'd0);
        chk("post_halt_count", 64'(Instr_Count), 64'd0);

        start_pulse();
        exec(32'h01A20000, 0, -1, len, rout, ctl, ill, dcnt);
        exec(32'h01A20000, 0, 4, len, rout, ctl, ill, dcnt);
        chk("abort_outs", 64'(dut_o), 64'd0);
        chk("abort_count", 64'(Instr_Count), 64'd0);
        @(posedge Clock);
        #1;
        chk("abort_idle", 64'(dut_o), 64'd0);
        start_pulse();
        exec(32'h4A920000, 2, -1, len, rout, ctl, ill, dcnt);
        chk("restart_count", 64'(Instr_Count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that sits directly upstream of `Datapath` and drives its control inputs. It replaces hand-sequenced stimulus with a Moore state machine. The machine runs the fetch sequence (T0–T2), decodes `IR`, and runs the register-to-register ALU execute steps. It retires one instruction per pass and stops on `halt`.

## Interface
Parameters:
- `ALU_W`, 5: width of `CONTROL`.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Clear` in 1: reset, synchronous, active-high.
- `Start` in 1: leave `IDLE` and begin fetching.
- `Mem_Ready` in 1: memory data valid on `MData_In` this cycle.
- `IR` in 32: instruction register contents from `Datapath`.
- `PC_Out`, `ZLO_Out`, `MDR_Out` out 1 each: bus drive enables.
- `MAR_In`, `PC_In`, `MDR_In`, `IR_In`, `Y_In`, `Z_In` out 1 each: register load enables.
- `IncPC` out 1: ALU performs PC+1 into Z.
- `Read` out 1: MDR selects `MData_In`.
- `R_In` out 16: one-hot general-register load enables.
- `R_Out` out 16: one-hot general-register bus drive enables.
- `CONTROL` out `ALU_W`: ALU operation select.
- `Run` out 1: high in every state except `IDLE` and `HALT`.
- `Illegal` out 1: one-cycle pulse on an unimplemented opcode.
- `Instr_Count` out `CNT_W`: number of instructions retired since `Clear`.

## Operation
- Instruction fields:
  - `op = IR[31:27]`, `ra = IR[26:23]`, `rb = IR[22:19]`, `rc = IR[18:15]`.
- Opcode decode:
  - Binary ALU ops are `op` 00000–01000. They use `CONTROL = op`.
  - Unary ops are `neg` (01001) → `CONTROL = 01010` and `not` (01010) → `CONTROL = 01011`.
  - `halt` is 11011.
  - Every other opcode is illegal.
- States: `IDLE, T0, T1, T2, T3, T4, T5, HALT`.
- Outputs are a pure decode of the state register plus `IR`, so each output is valid for the whole cycle. Every output not listed for a state is 0.
  - `T0`: `PC_Out, MAR_In, IncPC, Z_In`.
  - `T1`: `ZLO_Out, PC_In, Read, MDR_In`.
  - `T2`: `MDR_Out, IR_In`.
  - `T3`, binary op: `R_Out[rb], Y_In`.
  - `T3`, unary op: `R_Out[rb], CONTROL, Z_In`.
  - `T4`, binary op: `R_Out[rc], CONTROL, Z_In`.
  - `T4`, unary op: `ZLO_Out, R_In[ra]`.
  - `T5`, binary op: `ZLO_Out, R_In[ra]`.
  - `CONTROL` is 0 in every state where it is not listed.
- Transitions:
  - `IDLE` → `T0` when `Start`.
  - `T0` → `T1`.
  - `T1` → `T2` when `Mem_Ready`; otherwise stay in `T1`. Reloading PC from an unchanged Z is harmless.
  - `T2` → `T3`. Decode uses `IR` as loaded at the `T2` edge.
  - `T3`, when `halt`: → `HALT`.
  - `T3`, when illegal: → `T0`, with `Illegal` high during that `T3` cycle.
  - `T3`, otherwise: → `T4`.
  - `T4`, unary op: → `T0`.
  - `T4`, binary op: → `T5`.
  - `T5` → `T0`.
  - `HALT` stays in `HALT` until `Clear`.
- In `T3`, `halt` and illegal opcodes assert no datapath enables.
- `Instr_Count` increments by 1 on the last execute cycle of each legal ALU instruction:
  - unary op: the `T4` cycle;
  - binary op: the `T5` cycle.
  - It wraps modulo 2^`CNT_W`.
  - `halt` and illegal opcodes do not count.
- `R_In`/`R_Out` are zero-extended one-hot decodes of 4-bit fields. At most one bit of each is high per cycle.

## Timing
- Reset values (`Clear` high at an edge):
  - state = `IDLE`;
  - every output = 0;
  - `Instr_Count` = 0.
- `Clear` has priority over `Start`, `Mem_Ready`, and every state transition, including mid-instruction. Registers partially written in the datapath are not restored.
- `Start` is sampled only in `IDLE`.
- Latency from `Start` high at edge N:
  - `T0` outputs are valid in cycle N+1.
  - Without stalls, a unary op retires in 5 cycles (T0–T4).
  - Without stalls, a binary op retires in 6 cycles (T0–T5).
  - Each cycle with `Mem_Ready` low in `T1` adds one cycle.
- Back-to-back instructions have zero bubble: `T0` follows the last execute step directly.
- `Illegal` is high only in the `T3` cycle of an illegal opcode.

## Test plan
- Reset, then one-cycle `Start`; `Mem_Ready` held at 1 throughout:
  - the fetch cycles show the `T0`, `T1`, `T2` output sets exactly.
  - `Run` rises in the first `T0` cycle.
- `IR = 32'h4A920000` (`neg r5, r2`):
  - `T3`: `R_Out = 16'h0004`, `CONTROL = 01010`, `Z_In = 1`.
  - `T4`: `ZLO_Out = 1`, `R_In = 16'h0020`.
  - Then `T0`; `Instr_Count` = 1.
- `IR = 32'h01A20000` (add, ra=3, rb=4, rc=4):
  - `T3`: `R_Out = 16'h0010`, `Y_In = 1`.
  - `T4`: `R_Out = 16'h0010`, `CONTROL = 00000`, `Z_In = 1`.
  - `T5`: `R_In = 16'h0008`.
  - 6-cycle instruction.
- Hold `Mem_Ready` = 0 for 3 cycles in `T1`:
  - the state stays in `T1` for 4 cycles in total, with identical outputs.
  - `IR_In` is asserted only after `Mem_Ready` = 1.
- Opcode 11100, then opcode 11011:
  - for 11100: one `Illegal` pulse, return to `T0`, count unchanged.
  - for 11011: `HALT` reached; `Run` = 0 and all enables 0 until `Clear`.
- Assert `Clear` during the `T4` of a binary op:
  - the next cycle is `IDLE` with all outputs 0 and `Instr_Count` = 0.
  - `Start` asserted together with `Clear` is ignored.
